// File: rtl/dense_layer_ctrl.sv
// Sequencer for a time-multiplexed dense layer sharing one signed MAC across all output neurons.
// Latency: OUT_SIZE*(IN_SIZE+3)+1 cycles from start sample to done pulse; one result write per IN_SIZE+3 cycles.
// No backpressure: the memories must return data one cycle after each address; abort cancels at any time.
module dense_layer_ctrl #(
    parameter int IN_SIZE  = 128,
    parameter int OUT_SIZE = 64,
    parameter int DATA_W   = 16,
    parameter int W_W      = 16,
    parameter int B_W      = 32,
    parameter int ACC_W    = 40,
    parameter int OUT_W    = 24,
    parameter int SHIFT    = 8,
    localparam int IA_W    = (IN_SIZE > 1) ? $clog2(IN_SIZE) : 1,
    localparam int WA_W    = ((IN_SIZE * OUT_SIZE) > 1) ? $clog2(IN_SIZE * OUT_SIZE) : 1,
    localparam int JW      = (OUT_SIZE > 1) ? $clog2(OUT_SIZE) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    output logic              busy,
    output logic              done,
    output logic [IA_W-1:0]   in_addr,
    input  logic [DATA_W-1:0] in_data,
    output logic [WA_W-1:0]   w_addr,
    input  logic [W_W-1:0]    w_data,
    output logic [JW-1:0]     b_addr,
    input  logic [B_W-1:0]    b_data,
    output logic              out_wr_en,
    output logic [JW-1:0]     out_addr,
    output logic [OUT_W-1:0]  out_data
);

    localparam int PROD_W = DATA_W + W_W;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_BIAS  = 3'd1,
        S_MAC   = 3'd2,
        S_DRAIN = 3'd3,
        S_WRITE = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    state_t r_state;
    state_t w_next;

    // Loop counters: r_i walks the input vector, r_j walks output neurons.
    logic [IA_W-1:0]         r_i;
    logic [JW-1:0]           r_j;

    // Registered memory addresses; they hold their value while unused.
    logic [IA_W-1:0]         r_in_addr;
    logic [WA_W-1:0]         r_w_addr;
    logic [JW-1:0]           r_b_addr;
    logic [JW-1:0]           r_out_addr;

    logic signed [ACC_W-1:0] r_acc;
    logic [OUT_W-1:0]        r_out_data;

    logic                    w_last_i;
    logic                    w_last_j;
    logic signed [PROD_W-1:0] w_prod;
    logic signed [ACC_W-1:0] w_prod_ext;
    logic signed [ACC_W-1:0] w_bias_ext;
    logic signed [ACC_W-1:0] w_shifted;
    logic [OUT_W-1:0]        w_result;

    assign w_last_i = (r_i == IA_W'(IN_SIZE - 1));
    assign w_last_j = (r_j == JW'(OUT_SIZE - 1));

    // The memories return data for the previous cycle's address, so the
    // product here always belongs to the element issued one cycle earlier.
    assign w_prod     = $signed(in_data) * $signed(w_data);
    assign w_prod_ext = ACC_W'(w_prod);
    assign w_bias_ext = ACC_W'($signed(b_data));

    // Post-processing: arithmetic scale-down, ReLU clamp, then saturate to
    // the unsigned output range.
    assign w_shifted = r_acc >>> SHIFT;

    // Result function applied to the finished accumulator.
    always_comb begin
        w_result = '0;
        if (w_shifted[ACC_W-1]) begin
            w_result = '0;
        end else if (|w_shifted[ACC_W-2:OUT_W]) begin
            w_result = '1;
        end else begin
            w_result = w_shifted[OUT_W-1:0];
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic; abort overrides every transition, including a
    // start arriving in the same IDLE cycle.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (start) w_next = S_BIAS;
            S_BIAS:  w_next = S_MAC;
            S_MAC:   if (w_last_i) w_next = S_DRAIN;
            S_DRAIN: w_next = S_WRITE;
            S_WRITE: w_next = w_last_j ? S_DONE : S_BIAS;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
        if (abort) begin
            w_next = S_IDLE;
        end
    end

    // Control outputs decoded directly from the current state.
    always_comb begin
        busy      = (r_state != S_IDLE);
        done      = (r_state == S_DONE);
        out_wr_en = (r_state == S_WRITE);
    end

    // Datapath: counters, addresses, accumulator and held output value.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_i        <= '0;
            r_j        <= '0;
            r_in_addr  <= '0;
            r_w_addr   <= '0;
            r_b_addr   <= '0;
            r_out_addr <= '0;
            r_acc      <= '0;
            r_out_data <= '0;
        end else if (abort) begin
            r_i   <= '0;
            r_j   <= '0;
            r_acc <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_j      <= '0;
                        r_b_addr <= '0;
                    end
                end
                S_BIAS: begin
                    r_i       <= '0;
                    r_in_addr <= '0;
                    r_w_addr  <= WA_W'(r_j) * WA_W'(IN_SIZE);
                end
                S_MAC: begin
                    // Bias arrives on the first MAC cycle and seeds the sum;
                    // every later cycle folds in one product.
                    if (r_i == '0) begin
                        r_acc <= w_bias_ext;
                    end else begin
                        r_acc <= r_acc + w_prod_ext;
                    end
                    if (!w_last_i) begin
                        r_i       <= r_i + IA_W'(1);
                        r_in_addr <= r_in_addr + IA_W'(1);
                        r_w_addr  <= r_w_addr + WA_W'(1);
                    end
                end
                S_DRAIN: begin
                    r_acc      <= r_acc + w_prod_ext;
                    r_out_addr <= r_j;
                end
                S_WRITE: begin
                    r_out_data <= w_result;
                    if (w_last_j) begin
                        r_j <= '0;
                    end else begin
                        r_j      <= r_j + JW'(1);
                        r_b_addr <= r_j + JW'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign in_addr  = r_in_addr;
    assign w_addr   = r_w_addr;
    assign b_addr   = r_b_addr;
    assign out_addr = r_out_addr;
    // During the write cycle the fresh result is presented; otherwise the
    // last written value is held.
    assign out_data = (r_state == S_WRITE) ? w_result : r_out_data;

endmodule

// File: tb/tb_dense_layer_ctrl.sv
module tb_dense_layer_ctrl;

    localparam int IN_SIZE  = 4;
    localparam int OUT_SIZE = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic        busy;
    logic        done;
    logic [1:0]  in_addr;
    logic [15:0] in_data;
    logic [2:0]  w_addr;
    logic [15:0] w_data;
    logic [0:0]  b_addr;
    logic [31:0] b_data;
    logic        out_wr_en;
    logic [0:0]  out_addr;
    logic [23:0] out_data;

    dense_layer_ctrl #(
        .IN_SIZE(IN_SIZE), .OUT_SIZE(OUT_SIZE), .DATA_W(16), .W_W(16),
        .B_W(32), .ACC_W(40), .OUT_W(24), .SHIFT(8)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .busy(busy), .done(done),
        .in_addr(in_addr), .in_data(in_data),
        .w_addr(w_addr), .w_data(w_data),
        .b_addr(b_addr), .b_data(b_data),
        .out_wr_en(out_wr_en), .out_addr(out_addr), .out_data(out_data)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Synchronous single-read-port memory models.
    logic [15:0] in_mem [IN_SIZE];
    logic [15:0] w_mem  [IN_SIZE*OUT_SIZE];
    logic [31:0] b_mem  [OUT_SIZE];
    always @(posedge clk) begin
        in_data <= in_mem[in_addr];
        w_data  <= w_mem[w_addr];
        b_data  <= b_mem[b_addr];
    end

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input longint act, input longint exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Scoreboard: expected writes and done pulses with their absolute cycle.
    typedef struct {
        int cyc;
        int addr;
        int data;
    } wr_t;
    wr_t wq[$];
    int  dq[$];

    always @(negedge clk) begin : monitor
        wr_t e;
        int  dc;
        if (rst) begin
            if (out_wr_en) begin
                if (wq.size() == 0) begin
                    check("unexpected_write", 1, 0);
                end else begin
                    e = wq.pop_front();
                    check("write_cycle", longint'(cyc), longint'(e.cyc));
                    check("write_addr", longint'(out_addr), longint'(e.addr));
                    check("write_data", longint'(out_data), longint'(e.data));
                end
            end
            if (done) begin
                if (dq.size() == 0) begin
                    check("unexpected_done", 1, 0);
                end else begin
                    dc = dq.pop_front();
                    check("done_cycle", longint'(cyc), longint'(dc));
                end
            end
        end
    end

    // Fill memories: one input value everywhere, per-neuron weight and bias.
    task automatic set_mem(input int inv, input int w0, input int w1, input int b0, input int b1);
        for (int i = 0; i < IN_SIZE; i++) begin
            in_mem[i]           = 16'(inv);
            w_mem[i]            = 16'(w0);
            w_mem[IN_SIZE + i]  = 16'(w1);
        end
        b_mem[0] = 32'(b0);
        b_mem[1] = 32'(b1);
    endtask

    // Full layer run. Cycle n (spec numbering) is observed at the negedge
    // where cyc == s + n, s being the cyc value when start is raised.
    task automatic run_layer(input int o0, input int o1, input bit pulse5, input bit chk_addr);
        int s;
        @(negedge clk);
        s = cyc;
        start = 1'b1;
        wq.push_back('{s + 7,  0, o0});
        wq.push_back('{s + 14, 1, o1});
        dq.push_back(s + 15);
        for (int n = 1; n <= 16; n++) begin
            @(negedge clk);
            start = pulse5 && (n == 5);
            check("busy", longint'(busy), longint'(n <= 15));
            if (chk_addr && n == 8)
                check("b_addr_j1", longint'(b_addr), 1);
            if (chk_addr && n >= 9 && n <= 12) begin
                check("w_addr_j1", longint'(w_addr), longint'(n - 5));
                check("in_addr_j1", longint'(in_addr), longint'(n - 9));
            end
        end
        start = 1'b0;
        check("writes_drained", longint'(wq.size()), 0);
        check("done_drained", longint'(dq.size()), 0);
    endtask

    task automatic run_abort();
        int s;
        @(negedge clk);
        s = cyc;
        start = 1'b1;
        wq.push_back('{s + 7, 0, 1024});
        for (int n = 1; n <= 14; n++) begin
            @(negedge clk);
            start = 1'b0;
            abort = (n == 9);
            if (n >= 10)
                check("busy_after_abort", longint'(busy), 0);
        end
        abort = 1'b0;
        check("abort_writes", longint'(wq.size()), 0);
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_busy"}, longint'(busy), 0);
        check({tag, "_done"}, longint'(done), 0);
        check({tag, "_wr_en"}, longint'(out_wr_en), 0);
        check({tag, "_out_data"}, longint'(out_data), 0);
        check({tag, "_in_addr"}, longint'(in_addr), 0);
        check({tag, "_w_addr"}, longint'(w_addr), 0);
        check({tag, "_b_addr"}, longint'(b_addr), 0);
        check({tag, "_out_addr"}, longint'(out_addr), 0);
    endtask

    task automatic run_reset();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_zero_outputs("midrun_rst");
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("idle_after_rst", longint'(busy), 0);
    endtask

    initial begin
        set_mem(256, 256, 256, 0, 0);
        repeat (3) @(negedge clk);
        check_zero_outputs("reset");
        rst = 1'b1;
        @(negedge clk);

        // abort together with start in IDLE: stay idle
        start = 1'b1;
        abort = 1'b1;
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        check("start_with_abort", longint'(busy), 0);

        // basic: 4*256*256 >>> 8 = 1024 for both neurons
        run_layer(1024, 1024, 1'b0, 1'b0);
        // neuron 1 negative sum -> ReLU 0
        set_mem(256, 256, -256, 0, 0);
        run_layer(1024, 0, 1'b0, 1'b0);
        // saturation: (2^31-1 + 4*32767^2) >>> 8 > 2^24-1; bias -5 -> -1 -> 0
        set_mem(32767, 32767, 0, 2147483647, -5);
        run_layer(24'hFFFFFF, 0, 1'b0, 1'b0);
        // 256000 >>> 8 = 1000; start pulse mid-run ignored; address checks
        set_mem(256, 0, 256, 256000, 0);
        run_layer(1000, 1024, 1'b1, 1'b1);
        // abort during neuron 1, then a clean rerun
        set_mem(256, 256, 256, 0, 0);
        run_abort();
        run_layer(1024, 1024, 1'b0, 1'b0);
        // reset mid-run, then a full run
        run_reset();
        set_mem(256, 256, -256, 0, 0);
        run_layer(1024, 0, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
